// File: rtl/htif_responder_pkg.sv
// Shared definitions for the HTIF responder: default register map,
// STATUS bit layout and the request FSM state encoding.
package htif_responder_pkg;

  localparam logic [11:0] HTIF_TOHOST_ADDR   = 12'h780;
  localparam logic [11:0] HTIF_FROMHOST_ADDR = 12'h784;
  localparam logic [11:0] HTIF_CONSOLE_ADDR  = 12'h788;
  localparam logic [11:0] HTIF_STATUS_ADDR   = 12'h78C;
  localparam logic [11:0] HTIF_CYCLES_ADDR   = 12'h790;

  localparam int STATUS_DONE_BIT    = 0;
  localparam int STATUS_FAIL_BIT    = 1;
  localparam int STATUS_TIMEOUT_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1,
    ST_HALT = 2'd2
  } htif_state_t;

  // Assemble the STATUS word; all bits not named here read as zero.
  function automatic logic [31:0] pack_status(input logic done,
                                              input logic fail,
                                              input logic timeout);
    logic [31:0] s;
    s = '0;
    s[STATUS_DONE_BIT]    = done;
    s[STATUS_FAIL_BIT]    = fail;
    s[STATUS_TIMEOUT_BIT] = timeout;
    return s;
  endfunction

endpackage

// File: rtl/htif_watchdog.sv
// Free-running CYCLES counter plus the watchdog that ends a run which never
// reports a result. The watchdog stops counting once freeze is raised.
module htif_watchdog #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        freeze,
  output logic [31:0] cycles,
  output logic        expire
);

  // A limit of zero disables the watchdog entirely.
  localparam bit          ENABLE = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] LIMIT  = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] wd_count;

  // CYCLES counts every clock since reset and wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycles <= '0;
    end else begin
      cycles <= cycles + 32'd1;
    end
  end

  // Watchdog count advances only while the run is still undecided.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_count <= '0;
    end else if (!freeze) begin
      wd_count <= wd_count + 32'd1;
    end
  end

  // Fire on the edge at which the count reaches the limit, so the sticky
  // timeout flag becomes visible together with that count value.
  assign expire = ENABLE && !freeze && ((wd_count + 32'd1) == LIMIT);

endmodule

// File: rtl/htif_responder.sv
// Target-side HTIF responder: accepts single-word requests from the core,
// records the test result written to TOHOST, prints CONSOLE characters,
// serves FROMHOST/STATUS/CYCLES reads and ends the run on result or timeout.
module htif_responder
  import htif_responder_pkg::*;
#(
  parameter int                ADDR_W         = 12,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(HTIF_TOHOST_ADDR),
  parameter logic [ADDR_W-1:0] FROMHOST_ADDR  = ADDR_W'(HTIF_FROMHOST_ADDR),
  parameter logic [ADDR_W-1:0] CONSOLE_ADDR   = ADDR_W'(HTIF_CONSOLE_ADDR),
  parameter logic [ADDR_W-1:0] STATUS_ADDR    = ADDR_W'(HTIF_STATUS_ADDR),
  parameter logic [ADDR_W-1:0] CYCLES_ADDR    = ADDR_W'(HTIF_CYCLES_ADDR),
  parameter int                TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  input  logic              host_fromhost_we,
  input  logic [31:0]       host_fromhost_data,
  output logic              con_valid,
  output logic [7:0]        con_char,
  output logic              done,
  output logic              pass,
  output logic [30:0]       fail_code,
  output logic              timeout
);

  htif_state_t state, state_next;

  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [7:0]        lat_char;
  logic [31:0]       tohost;
  logic [31:0]       fromhost;
  logic [31:0]       cycles;
  logic              accept;
  logic              wr_tohost;
  logic              wr_fromhost;
  logic              tohost_done;
  logic              expire;

  // Requests are only taken in IDLE, never once the run has ended, and
  // never while reset is held.
  assign req_ready   = (state == ST_IDLE) && !done && !reset;
  assign accept      = req_valid && req_ready;
  assign wr_tohost   = accept && req_we && (req_addr == TOHOST_ADDR);
  assign wr_fromhost = accept && req_we && (req_addr == FROMHOST_ADDR);
  assign tohost_done = wr_tohost && req_wdata[0];

  htif_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .freeze(done),
    .cycles(cycles),
    .expire(expire)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and response outputs; the response is decoded from the
  // latched request during the single RESP cycle.
  always_comb begin
    state_next = state;
    resp_valid = 1'b0;
    resp_rdata = '0;
    con_valid  = 1'b0;
    con_char   = '0;
    case (state)
      ST_IDLE: begin
        if (done) begin
          state_next = ST_HALT;
        end else if (accept) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_next = done ? ST_HALT : ST_IDLE;
        if (lat_we) begin
          if (lat_addr == CONSOLE_ADDR) begin
            con_valid = 1'b1;
            con_char  = lat_char;
          end
        end else if (lat_addr == TOHOST_ADDR) begin
          resp_rdata = tohost;
        end else if (lat_addr == FROMHOST_ADDR) begin
          resp_rdata = fromhost;
        end else if (lat_addr == STATUS_ADDR) begin
          resp_rdata = pack_status(done, done && !pass, timeout);
        end else if (lat_addr == CYCLES_ADDR) begin
          resp_rdata = cycles;
        end
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Capture the accepted request so the RESP cycle can decode it.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_we   <= 1'b0;
      lat_addr <= '0;
      lat_char <= '0;
    end else if (accept) begin
      lat_we   <= req_we;
      lat_addr <= req_addr;
      lat_char <= req_wdata[7:0];
    end
  end

  // TOHOST holds whatever the core last wrote, result or not.
  always_ff @(posedge clk) begin
    if (reset) begin
      tohost <= '0;
    end else if (wr_tohost) begin
      tohost <= req_wdata;
    end
  end

  // Host load has priority over the core's acknowledge-clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      fromhost <= '0;
    end else if (host_fromhost_we) begin
      fromhost <= host_fromhost_data;
    end else if (wr_fromhost) begin
      fromhost <= '0;
    end
  end

  // Sticky run result; a TOHOST result beats a watchdog expiry on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_code <= '0;
      timeout   <= 1'b0;
    end else if (!done) begin
      if (tohost_done) begin
        done      <= 1'b1;
        pass      <= (req_wdata == 32'd1);
        fail_code <= req_wdata[31:1];
      end else if (expire) begin
        done    <= 1'b1;
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_htif_responder.sv
// Self-checking bench for htif_responder: a register-level model of the
// HTIF map is compared against the DUT every cycle, alongside directed
// transactions with hand-computed expectations.
`timescale 1ns/1ps
module tb_htif_responder;

  localparam int          TO         = 50;
  localparam logic [11:0] A_TOHOST   = 12'h780;
  localparam logic [11:0] A_FROMHOST = 12'h784;
  localparam logic [11:0] A_CONSOLE  = 12'h788;
  localparam logic [11:0] A_STATUS   = 12'h78C;
  localparam logic [11:0] A_CYCLES   = 12'h790;
  localparam logic [11:0] A_UNMAPPED = 12'h7A0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        host_fromhost_we = 1'b0;
  logic [31:0] host_fromhost_data = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        con_valid;
  logic [7:0]  con_char;
  logic        done;
  logic        pass;
  logic [30:0] fail_code;
  logic        timeout;

  int checks = 0;
  int errors = 0;
  int tb_edge = 0;
  int reset_edge = 0;

  htif_responder #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_we            (req_we),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .resp_valid        (resp_valid),
    .resp_rdata        (resp_rdata),
    .host_fromhost_we  (host_fromhost_we),
    .host_fromhost_data(host_fromhost_data),
    .con_valid         (con_valid),
    .con_char          (con_char),
    .done              (done),
    .pass              (pass),
    .fail_code         (fail_code),
    .timeout           (timeout)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Edge counter used for latency/spacing measurements.
  always @(posedge clk) tb_edge++;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: what the outputs must be after the most recent edge.
  bit          m_started = 1'b0;
  bit          m_ready = 1'b0;
  bit          m_done = 1'b0;
  bit          m_pass = 1'b0;
  bit          m_timeout = 1'b0;
  bit          m_resp_valid = 1'b0;
  bit          m_con_valid = 1'b0;
  logic [31:0] m_tohost = '0;
  logic [31:0] m_fromhost = '0;
  logic [31:0] m_cyc = '0;
  logic [31:0] m_rdata = '0;
  logic [30:0] m_fail = '0;
  logic [7:0]  m_char = '0;

  function automatic logic [31:0] model_read(input logic [11:0] a);
    if (a == A_TOHOST)   return m_tohost;
    if (a == A_FROMHOST) return m_fromhost;
    if (a == A_STATUS)   return {29'b0, m_timeout, m_done && !m_pass, m_done};
    if (a == A_CYCLES)   return m_cyc;
    return 32'd0;
  endfunction

  // Register-map model advanced once per clock from the sampled inputs.
  always @(posedge clk) begin
    bit acc;
    bit expire;
    if (reset) begin
      m_started = 1'b1;
      m_ready = 1'b1;
      m_done = 1'b0; m_pass = 1'b0; m_timeout = 1'b0; m_fail = '0;
      m_tohost = '0; m_fromhost = '0; m_cyc = '0;
      m_resp_valid = 1'b0; m_rdata = '0; m_con_valid = 1'b0; m_char = '0;
    end else if (m_started) begin
      acc = req_valid && m_ready;
      m_cyc = m_cyc + 32'd1;
      // While undecided the watchdog equals cycles since reset.
      expire = !m_done && (m_cyc == 32'(TO - 1));
      if (acc && req_we && req_addr == A_TOHOST) m_tohost = req_wdata;
      if (!m_done) begin
        if (acc && req_we && req_addr == A_TOHOST && req_wdata[0]) begin
          m_done = 1'b1; m_pass = (req_wdata == 32'd1); m_fail = req_wdata[31:1];
        end else if (expire) begin
          m_done = 1'b1; m_timeout = 1'b1;
        end
      end
      if (host_fromhost_we) m_fromhost = host_fromhost_data;
      else if (acc && req_we && req_addr == A_FROMHOST) m_fromhost = '0;
      m_resp_valid = acc;
      m_rdata = (acc && !req_we) ? model_read(req_addr) : 32'd0;
      m_con_valid = acc && req_we && (req_addr == A_CONSOLE);
      if (m_con_valid) m_char = req_wdata[7:0];
      m_ready = !acc && !m_done;
    end
  end

  // Compare DUT against the model mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_started) begin
      check_output("req_ready", 32'(req_ready), 32'(m_ready && !reset));
      check_output("resp_valid", 32'(resp_valid), 32'(m_resp_valid));
      if (m_resp_valid) check_output("resp_rdata", resp_rdata, m_rdata);
      check_output("con_valid", 32'(con_valid), 32'(m_con_valid));
      if (m_con_valid) check_output("con_char", 32'(con_char), 32'(m_char));
      check_output("done", 32'(done), 32'(m_done));
      check_output("pass", 32'(pass), 32'(m_pass));
      check_output("fail_code", 32'(fail_code), 32'(m_fail));
      check_output("timeout", 32'(timeout), 32'(m_timeout));
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset_edge = tb_edge;
    check_output("ready_in_reset", 32'(req_ready), 32'd0);
    reset = 1'b0;
    #1;
    check_output("ready_after_reset", 32'(req_ready), 32'd1);
  endtask

  // Present one request until accepted or the budget runs out; returns
  // 1ns after the accepting edge, i.e. inside the response cycle.
  task automatic apply_stimulus(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                                input int budget, output bit accepted);
    bit seen;
    accepted = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    for (int i = 0; i < budget && !accepted; i++) begin
      @(negedge clk);
      seen = req_ready;
      @(posedge clk);
      #1;
      if (seen) accepted = 1'b1;
    end
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic xact(input logic we, input logic [11:0] addr, input logic [31:0] wdata);
    bit acc;
    apply_stimulus(we, addr, wdata, 4, acc);
    check_output("accept_within_budget", 32'(acc), 32'd1);
  endtask

  // Global bound so a stuck DUT can never hang the run.
  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation exceeded time bound");
    $fatal(1, "[TB] aborted");
  end

  // Directed test sequence.
  initial begin
    bit acc;
    int t1;
    int t2;

    // Reset, CYCLES/STATUS/unmapped reads.
    do_reset();
    xact(1'b0, A_CYCLES, 32'd0);
    check_output("cycles_first_read", resp_rdata, 32'd1);
    xact(1'b0, A_STATUS, 32'd0);
    check_output("status_resp_valid", 32'(resp_valid), 32'd1);
    check_output("status_after_reset", resp_rdata, 32'd0);
    @(posedge clk); #1;
    check_output("resp_one_cycle", 32'(resp_valid), 32'd0);
    xact(1'b1, A_UNMAPPED, 32'h1234_5678);
    xact(1'b0, A_UNMAPPED, 32'd0);
    check_output("unmapped_read", resp_rdata, 32'd0);

    // Non-result TOHOST write, then a failing result.
    do_reset();
    xact(1'b1, A_TOHOST, 32'h6);
    check_output("tohost6_no_done", 32'(done), 32'd0);
    xact(1'b0, A_TOHOST, 32'd0);
    check_output("tohost6_readback", resp_rdata, 32'h6);
    xact(1'b1, A_TOHOST, 32'h7);
    check_output("tohost7_done", 32'(done), 32'd1);
    check_output("tohost7_pass", 32'(pass), 32'd0);
    check_output("tohost7_code", 32'(fail_code), 32'd3);
    apply_stimulus(1'b0, A_STATUS, 32'd0, 6, acc);
    check_output("halt_after_fail", 32'(acc), 32'd0);

    // Passing result and halt.
    do_reset();
    xact(1'b1, A_TOHOST, 32'h1);
    check_output("tohost1_done", 32'(done), 32'd1);
    check_output("tohost1_pass", 32'(pass), 32'd1);
    check_output("tohost1_code", 32'(fail_code), 32'd0);
    apply_stimulus(1'b0, A_CYCLES, 32'd0, 6, acc);
    check_output("halt_after_pass", 32'(acc), 32'd0);

    // Back-to-back console characters.
    do_reset();
    xact(1'b1, A_CONSOLE, 32'h48);
    t1 = tb_edge;
    check_output("con_h_valid", 32'(con_valid), 32'd1);
    check_output("con_h_char", 32'(con_char), 32'h48);
    xact(1'b1, A_CONSOLE, 32'h69);
    t2 = tb_edge;
    check_output("con_i_valid", 32'(con_valid), 32'd1);
    check_output("con_i_char", 32'(con_char), 32'h69);
    check_output("con_spacing", 32'(t2 - t1), 32'd2);

    // fromhost: host load, core acknowledge, host-wins collision.
    do_reset();
    host_fromhost_we = 1'b1; host_fromhost_data = 32'hCAFE;
    @(posedge clk); #1;
    host_fromhost_we = 1'b0; host_fromhost_data = '0;
    xact(1'b0, A_FROMHOST, 32'd0);
    check_output("fromhost_cafe", resp_rdata, 32'hCAFE);
    xact(1'b1, A_FROMHOST, 32'h123);
    xact(1'b0, A_FROMHOST, 32'd0);
    check_output("fromhost_cleared", resp_rdata, 32'd0);
    host_fromhost_we = 1'b1; host_fromhost_data = 32'hBEEF;
    xact(1'b1, A_FROMHOST, 32'h55);
    host_fromhost_we = 1'b0; host_fromhost_data = '0;
    xact(1'b0, A_FROMHOST, 32'd0);
    check_output("fromhost_host_wins", resp_rdata, 32'hBEEF);

    // Watchdog expiry with no result.
    do_reset();
    repeat (TO - 2) @(posedge clk);
    #1;
    check_output("timeout_not_yet", 32'(timeout), 32'd0);
    @(posedge clk); #1;
    check_output("timeout_edge", 32'(tb_edge - reset_edge), 32'(TO - 1));
    check_output("timeout_set", 32'(timeout), 32'd1);
    check_output("timeout_done", 32'(done), 32'd1);
    check_output("timeout_pass", 32'(pass), 32'd0);
    apply_stimulus(1'b0, A_STATUS, 32'd0, 6, acc);
    check_output("halt_after_timeout", 32'(acc), 32'd0);

    // TOHOST=1 accepted on the expiry edge: the result wins.
    do_reset();
    repeat (TO - 2) @(posedge clk);
    #1;
    xact(1'b1, A_TOHOST, 32'h1);
    check_output("race_edge", 32'(tb_edge - reset_edge), 32'(TO - 1));
    check_output("race_pass", 32'(pass), 32'd1);
    check_output("race_timeout", 32'(timeout), 32'd0);

    // Reset clears everything again.
    do_reset();
    check_output("clear_done", 32'(done), 32'd0);
    check_output("clear_timeout", 32'(timeout), 32'd0);
    xact(1'b0, A_TOHOST, 32'd0);
    check_output("clear_tohost", resp_rdata, 32'd0);
    xact(1'b0, A_STATUS, 32'd0);
    check_output("clear_status", resp_rdata, 32'd0);

    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
